dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4, is the number of consecutive stalled cycles after which a pending DMA request overrides core priority (range 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 c_valid  input  1  core MEM-stage request valid.
REQ-005 c_ready  output  1  core request accepted this cycle; c_valid & ~c_ready drives the pipeline stall.
REQ-006 c_load, c_store  input  1 each  core access type.
REQ-007 c_addr, c_wdata  input  32 each  core byte address and store data.
REQ-008 c_func3  input  3  core RV32I load/store width code (instr[14:12]).
REQ-009 c_rdata  output  32  core load response data.
REQ-010 c_rvalid, c_err  output  1 each  core response strobe and error flag.
REQ-011 d_valid, d_ready, d_load, d_store, d_addr, d_wdata, d_func3, d_rdata, d_rvalid, d_err  same widths and directions as the core set  DMA/debug requester port.
REQ-012 mem_load, mem_store  output  1 each  data memory strobes.
REQ-013 mem_addr, mem_wdata  output  32 each  data memory address and write data.
REQ-014 mem_func3  output  3  width code to memory; mem_addr[1:0] serves as the byte lane.
REQ-015 mem_rdata  input  32  combinational data memory read data.

Function
REQ-016 The arbiter SHALL grant at most one request per cycle; a request is accepted when x_valid & x_ready is high at a rising clk edge.
REQ-017 When only one requester is valid, that requester SHALL be granted the same cycle (x_ready combinational, zero added latency).
REQ-018 When both are valid, the core SHALL win unless wait_cnt equals MAX_WAIT, in which case the DMA SHALL win.
REQ-019 wait_cnt SHALL increment on each edge with d_valid & ~d_ready, saturate at MAX_WAIT, and clear on a DMA grant or when d_valid is low.
REQ-020 The granted requester's addr, wdata, and func3 SHALL drive mem_*; with no grant, all mem_* outputs SHALL be 0.
REQ-021 Misaligned accesses (halfword with addr[0]=1; word with addr[1:0]!=00), func3 not legal for the access type, or load and store both asserted SHALL be accepted with mem_load=mem_store=0 and flagged as errors.
REQ-022 One cycle after an accepted load, the arbiter SHALL pulse x_rvalid=1 for one cycle with x_rdata set to the mem_rdata value registered at the accept edge.
REQ-023 One cycle after an accepted store, it SHALL pulse x_rvalid=1 with x_rdata=0; the store commits on the accept edge.
REQ-024 An error response SHALL pulse x_rvalid=1, x_err=1, x_rdata=0 one cycle after acceptance.
REQ-025 x_rvalid SHALL be low in every cycle not covered by REQ-022..024; the response register tracks the owner as IDLE, RESP_C or RESP_D and returns to IDLE when no request is accepted.
REQ-026 Back-to-back accepts SHALL be supported: a response and a new grant may occur in the same cycle.

Reset
REQ-027 While rst=0, all outputs SHALL be 0, wait_cnt SHALL be 0, and the response state SHALL be IDLE; any pending response is discarded, and no response follows a reset mid-operation.

Structure
REQ-028 Package dmem_arb_pkg SHALL hold the func3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the response-owner enum (IDLE, RESP_C, RESP_D).
REQ-029 Alignment and legality checking SHALL live in a combinational sub-module dmem_align_check, instantiated once on the granted request.

Verification
REQ-030 Core-only LW at addr 0x10 with mem_rdata 0xDEADBEEF -> c_ready=1 same cycle, then c_rvalid=1 and c_rdata=0xDEADBEEF next cycle, d_* responses idle.
REQ-031 Both requesters valid continuously, MAX_WAIT=4 -> core granted 4 cycles, DMA granted on cycle 5, wait_cnt back to 0, pattern repeats.
REQ-032 Core SH at addr 0x21 -> c_ready=1, mem_store=0, next cycle c_rvalid=1 and c_err=1.
REQ-033 DMA SW of 0x12345678 to 0x40, then core LW from 0x40 next cycle -> core returns 0x12345678.
REQ-034 rst asserted low in the cycle after an accepted load -> no c_rvalid pulse; all outputs 0 until rst is released.
REQ-035 DMA alone valid for 3 cycles with one load per cycle -> d_ready high every cycle, three consecutive d_rvalid pulses, each one cycle later.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: RV32I load/store width
// codes, the response-owner encoding and the request bundle.
package dmem_arb_pkg;

  // Load width codes (instr[14:12])
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store width codes (instr[14:12])
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Which requester owns the response slot in the current cycle
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_C = 2'd1,
    RESP_D = 2'd2
  } resp_owner_e;

  // One requester's access, as presented to the memory mux
  typedef struct packed {
    logic        load;
    logic        store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
  } mem_req_t;

endpackage

// File: rtl/dmem_align_check.sv
// Combinational legality check of a single load/store request: access type,
// width code and natural alignment.
module dmem_align_check
  import dmem_arb_pkg::*;
(
  input  logic       load,
  input  logic       store,
  input  logic [1:0] addr_lo,
  input  logic [2:0] func3,
  output logic       err
);

  logic misaligned;
  logic legal_load;
  logic legal_store;

  // Flag any request the memory must not see
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    misaligned  = 1'b0;
    legal_load  = 1'b0;
    legal_store = 1'b0;
    err         = 1'b0;

    case (func3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase

    legal_load  = func3 inside {LB, LH, LW, LBU, LHU};
    legal_store = func3 inside {SB, SH, SW};

    // A request that is neither load nor store has no defined meaning, so it
    // is refused the same way as one that is both.
    err = (load == store)
        | (load  & ~legal_load)
        | (store & ~legal_store)
        | misaligned;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: core has priority, DMA wins after
// MAX_WAIT stalled cycles. Single-cycle accept, registered one-cycle response.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // core port
  input  logic        c_valid,
  output logic        c_ready,
  input  logic        c_load,
  input  logic        c_store,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_func3,
  output logic [31:0] c_rdata,
  output logic        c_rvalid,
  output logic        c_err,
  // DMA / debug port
  input  logic        d_valid,
  output logic        d_ready,
  input  logic        d_load,
  input  logic        d_store,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_func3,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_err,
  // data memory
  output logic        mem_load,
  output logic        mem_store,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_func3,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]  wait_cnt, wait_nxt;
  logic        wait_sat;
  logic        c_gnt, d_gnt, acc, acc_err;
  mem_req_t    c_req, d_req, gnt_req;

  resp_owner_e owner_q, owner_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  assign c_req = '{load: c_load, store: c_store, addr: c_addr, wdata: c_wdata, func3: c_func3};
  assign d_req = '{load: d_load, store: d_store, addr: d_addr, wdata: d_wdata, func3: d_func3};

  // Grants are gated by rst so every output reads 0 while reset is held.
  assign wait_sat = (wait_cnt == MAX_WAIT_C);
  assign c_gnt    = rst & c_valid & ~(d_valid & wait_sat);
  assign d_gnt    = rst & d_valid & ~c_gnt;
  assign acc      = c_gnt | d_gnt;
  assign c_ready  = c_gnt;
  assign d_ready  = d_gnt;

  assign gnt_req = c_gnt ? c_req : (d_gnt ? d_req : '0);

  dmem_align_check u_align_check (
    .load    (gnt_req.load),
    .store   (gnt_req.store),
    .addr_lo (gnt_req.addr[1:0]),
    .func3   (gnt_req.func3),
    .err     (acc_err)
  );

  assign mem_load  = acc & gnt_req.load  & ~acc_err;
  assign mem_store = acc & gnt_req.store & ~acc_err;
  assign mem_addr  = gnt_req.addr;
  assign mem_wdata = gnt_req.wdata;
  assign mem_func3 = gnt_req.func3;

  // Starvation counter: counts DMA stall edges, saturating at MAX_WAIT
  always_comb begin
    wait_nxt = wait_cnt;
    if (!d_valid || d_gnt) begin
      wait_nxt = '0;
    end else if (!wait_sat) begin
      wait_nxt = wait_cnt + 4'd1;
    end
  end

  // Response slot next state: owner, captured data and error flag
  always_comb begin
    owner_d = IDLE;
    rdata_d = '0;
    err_d   = 1'b0;
    if (c_gnt) begin
      owner_d = RESP_C;
    end else if (d_gnt) begin
      owner_d = RESP_D;
    end
    if (acc) begin
      err_d   = acc_err;
      rdata_d = (gnt_req.load && !acc_err) ? mem_rdata : '0;
    end
  end

  // State registers; an asynchronous reset drops any pending response
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of statement order.
    if (!rst) begin
      wait_cnt <= '0;
      owner_q  <= IDLE;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      owner_q  <= owner_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Response slot drives only the requester that owns it
  assign c_rvalid = (owner_q == RESP_C);
  assign d_rvalid = (owner_q == RESP_D);
  assign c_rdata  = c_rvalid ? rdata_q : '0;
  assign d_rdata  = d_rvalid ? rdata_q : '0;
  assign c_err    = c_rvalid & err_q;
  assign d_err    = d_rvalid & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int MAX_WAIT = 4;

  logic        clk, rst;
  logic        c_valid, c_ready, c_load, c_store, c_rvalid, c_err;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [2:0]  c_func3;
  logic        d_valid, d_ready, d_load, d_store, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_func3;
  logic        mem_load, mem_store;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_func3;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  // Bench-side data memory, 64 words, with a preset port for test setup
  logic [31:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_val;
    end else if (mem_store) begin
      case (mem_func3[1:0])
        2'b00:   mem[mem_addr[7:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
        2'b01:   mem[mem_addr[7:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
        default: mem[mem_addr[7:2]] <= mem_wdata;
      endcase
    end
  end

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .c_valid(c_valid), .c_ready(c_ready), .c_load(c_load), .c_store(c_store),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_func3(c_func3),
    .c_rdata(c_rdata), .c_rvalid(c_rvalid), .c_err(c_err),
    .d_valid(d_valid), .d_ready(d_ready), .d_load(d_load), .d_store(d_store),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_func3(d_func3),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_err(d_err),
    .mem_load(mem_load), .mem_store(mem_store), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_c(input bit v, input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    c_valid = v; c_load = ld; c_store = st; c_func3 = f3; c_addr = a; c_wdata = wd;
  endtask

  task automatic drive_d(input bit v, input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    d_valid = v; d_load = ld; d_store = st; d_func3 = f3; d_addr = a; d_wdata = wd;
  endtask

  task automatic drive_idle();
    drive_c(0, 0, 0, 3'b000, 32'h0, 32'h0);
    drive_d(0, 0, 0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic mem_preset(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = 6'(idx); pre_val = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Returns with rst released, at a falling edge
  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [138:0] all_outputs();
    return {c_ready, c_rdata, c_rvalid, c_err, d_ready, d_rdata, d_rvalid, d_err,
            mem_load, mem_store, mem_addr, mem_wdata, mem_func3};
  endfunction

  // Reference legality rule: type, width code, natural alignment
  function automatic bit model_err(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] a);
    int size;
    if (ld == st) return 1'b1;
    if (ld && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    if (st && f3 > 3'd2) return 1'b1;
    size = 1 << f3[1:0];
    return (int'(a[1:0]) % size) != 0;
  endfunction

  task automatic rand_req(output bit ld, output bit st, output logic [2:0] f3,
                          output logic [31:0] a, output logic [31:0] wd);
    int k;
    k  = $urandom % 10;
    ld = (k < 5) || (k == 9);
    st = (k >= 5);
    if ($urandom % 6 == 0) begin
      f3 = 3'($urandom % 8);
    end else if (ld) begin
      case ($urandom % 5)
        0: f3 = LB;
        1: f3 = LH;
        2: f3 = LW;
        3: f3 = LBU;
        default: f3 = LHU;
      endcase
    end else begin
      f3 = 3'($urandom % 3);
    end
    a = 32'($urandom % 256);
    if ($urandom % 4 != 0) a[1:0] = 2'b00;
    wd = $urandom;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_c(1, 1, 0, LW, 32'h10, 32'h0);
    drive_d(1, 0, 1, SW, 32'h20, 32'hA5A5A5A5);
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", all_outputs());
    end
    @(negedge clk);
    checks++;
    if (all_outputs() !== '0) begin
      failures++;
      $display("FAIL reset_hold: got %h want 0", all_outputs());
    end
    drive_idle();
    rst = 1'b1;
  endtask

  task automatic test_core_load();
    mem_preset(4, 32'hDEADBEEF);
    @(negedge clk);
    drive_c(1, 1, 0, LW, 32'h10, 32'h0);
    #1;
    checks++;
    if ({c_ready, d_ready, mem_load, mem_store, mem_addr} !== {4'b1010, 32'h10}) begin
      failures++;
      $display("FAIL core_load_grant: got rdy=%b drdy=%b ld=%b st=%b addr=%h want 1 0 1 0 00000010",
               c_ready, d_ready, mem_load, mem_store, mem_addr);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({c_rvalid, c_err, c_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL core_load_resp: got v=%b e=%b d=%h want 1 0 deadbeef", c_rvalid, c_err, c_rdata);
    end
    checks++;
    if ({d_rvalid, d_err, d_rdata} !== '0) begin
      failures++;
      $display("FAIL core_load_dma_idle: got v=%b e=%b d=%h want 0", d_rvalid, d_err, d_rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if (c_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL core_load_single_pulse: got %b want 0", c_rvalid);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_c(1, 1, 0, LW, 32'h0, 32'h0);
      drive_d(1, 1, 0, LW, 32'h4, 32'h0);
      #1;
      checks++;
      if ({c_ready, d_ready, mem_addr} !== ((i % 5 == 4) ? {2'b01, 32'h4} : {2'b10, 32'h0})) begin
        failures++;
        $display("FAIL priority_cycle%0d: got c=%b d=%b addr=%h want winner %s",
                 i, c_ready, d_ready, mem_addr, (i % 5 == 4) ? "dma" : "core");
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    drive_c(1, 0, 1, SH, 32'h21, 32'h0000BEEF);
    #1;
    checks++;
    if ({c_ready, mem_store, mem_load} !== 3'b100) begin
      failures++;
      $display("FAIL misaligned_accept: got rdy=%b st=%b ld=%b want 1 0 0", c_ready, mem_store, mem_load);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({c_rvalid, c_err, c_rdata} !== {2'b11, 32'h0}) begin
      failures++;
      $display("FAIL misaligned_resp: got v=%b e=%b d=%h want 1 1 0", c_rvalid, c_err, c_rdata);
    end
  endtask

  task automatic test_store_then_load();
    mem_preset(16, 32'h0);
    @(negedge clk);
    drive_d(1, 0, 1, SW, 32'h40, 32'h12345678);
    #1;
    checks++;
    if ({d_ready, mem_store} !== 2'b11) begin
      failures++;
      $display("FAIL dma_store_grant: got rdy=%b st=%b want 1 1", d_ready, mem_store);
    end
    @(negedge clk);
    drive_d(0, 0, 0, 3'b000, 32'h0, 32'h0);
    drive_c(1, 1, 0, LW, 32'h40, 32'h0);
    #1;
    checks++;
    if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h0}) begin
      failures++;
      $display("FAIL dma_store_resp: got v=%b e=%b d=%h want 1 0 0", d_rvalid, d_err, d_rdata);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({c_rvalid, c_err, c_rdata} !== {2'b10, 32'h12345678}) begin
      failures++;
      $display("FAIL store_load_data: got v=%b e=%b d=%h want 1 0 12345678", c_rvalid, c_err, c_rdata);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_c(1, 1, 0, LW, 32'h8, 32'h0);
    drive_d(1, 1, 0, LW, 32'hC, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %h want 0", all_outputs());
    end
    @(negedge clk);
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      failures++;
      $display("FAIL reset_mid_hold: got %h want 0", all_outputs());
    end
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({c_rvalid, d_rvalid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_no_resp: got c=%b d=%b want 0 0", c_rvalid, d_rvalid);
    end
  endtask

  task automatic test_dma_stream();
    logic [31:0] vals [3];
    for (int i = 0; i < 3; i++) begin
      vals[i] = 32'hC0DE0000 + 32'(i * 17);
      mem_preset(20 + i, vals[i]);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) drive_d(1, 1, 0, LW, 32'(80 + 4 * i), 32'h0);
      else       drive_idle();
      #1;
      checks++;
      if (d_ready !== (i < 3)) begin
        failures++;
        $display("FAIL dma_stream_ready%0d: got %b want %b", i, d_ready, (i < 3));
      end
      if (i > 0) begin
        checks++;
        if ({d_rvalid, d_err, d_rdata} !== {2'b10, vals[i-1]}) begin
          failures++;
          $display("FAIL dma_stream_resp%0d: got v=%b e=%b d=%h want 1 0 %h",
                   i - 1, d_rvalid, d_err, d_rdata, vals[i-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    int          w;
    resp_t       exp_c, exp_d, nxt;
    bit          cv, dv, cl, cs, dl, ds, cw, dw, e, gl, gs;
    logic [2:0]  cf, df, gf;
    logic [31:0] ca, cd, da, dd, ga, gd;
    logic [70:0] exp_mem;
    apply_reset();
    w = 0; exp_c = '0; exp_d = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cv = ($urandom % 3) != 0;
      dv = ($urandom % 2) != 0;
      rand_req(cl, cs, cf, ca, cd);
      rand_req(dl, ds, df, da, dd);
      drive_c(cv, cl, cs, cf, ca, cd);
      drive_d(dv, dl, ds, df, da, dd);
      #1;
      cw = cv && !(dv && w == MAX_WAIT);
      dw = dv && !cw;
      checks++;
      if ({c_ready, d_ready} !== {cw, dw}) begin
        failures++;
        $display("FAIL rand_grant%0d: got c=%b d=%b want %b %b (wait=%0d)", i, c_ready, d_ready, cw, dw, w);
      end
      checks++;
      if ({c_rvalid, c_err, c_rdata} !== exp_c) begin
        failures++;
        $display("FAIL rand_core_resp%0d: got v=%b e=%b d=%h want %b %b %h",
                 i, c_rvalid, c_err, c_rdata, exp_c.valid, exp_c.err, exp_c.data);
      end
      checks++;
      if ({d_rvalid, d_err, d_rdata} !== exp_d) begin
        failures++;
        $display("FAIL rand_dma_resp%0d: got v=%b e=%b d=%h want %b %b %h",
                 i, d_rvalid, d_err, d_rdata, exp_d.valid, exp_d.err, exp_d.data);
      end
      gl = cw ? cl : dl;  gs = cw ? cs : ds;  gf = cw ? cf : df;
      ga = cw ? ca : da;  gd = cw ? cd : dd;
      e  = model_err(gl, gs, gf, ga);
      if (cw || dw) exp_mem = {gl && !e, gs && !e, ga, gd, gf};
      else          exp_mem = '0;
      checks++;
      if ({mem_load, mem_store, mem_addr, mem_wdata, mem_func3} !== exp_mem) begin
        failures++;
        $display("FAIL rand_mem%0d: got %h want %h", i,
                 {mem_load, mem_store, mem_addr, mem_wdata, mem_func3}, exp_mem);
      end
      nxt = '0;
      if (cw || dw) nxt = '{valid: 1'b1, err: e, data: (gl && !e) ? mem[ga[7:2]] : 32'h0};
      exp_c = cw ? nxt : '0;
      exp_d = dw ? nxt : '0;
      if (!dv || dw)        w = 0;
      else if (w < MAX_WAIT) w = w + 1;
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    rst = 1'b0;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    drive_idle();
    for (int i = 0; i < 64; i++) mem_preset(i, $urandom);
    test_reset();
    test_core_load();
    test_priority();
    test_misaligned();
    test_store_then_load();
    test_reset_mid();
    test_dma_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
